main_ctrl_stage: RTL and testbench
==================================

# main_ctrl_stage

- Registered, parametrised successor to the combinational main-control decoder.
- Decodes one RV32I instruction per handshake into the same control word (`o_Branch` … `o_CSR_en`), plus a precise exception cause, and holds the result in an output pipeline register with valid/ready flow control.
- Serialises SYSTEM and FENCE instructions: they are held until the downstream pipeline reports empty.
- Sits between fetch and the ID/EX register.

## Interface
Parameters:
- `XLEN`, 32, PC width.
- `CAUSE_W`, 4, exception-cause width (≥4).

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous assert, active-low.
- `i_valid` in 1: fetch presents `i_Instr` / `i_pc`.
- `o_ready` out 1: stage accepts this cycle.
- `i_Instr` in 32: instruction.
- `i_pc` in XLEN: PC of `i_Instr`.
- `i_flush` in 1: kill held and buffered instruction.
- `i_pipe_empty` in 1: no older instruction in EX/MEM/WB.
- `o_valid` out 1: control word valid.
- `i_ready` in 1: downstream accepts.
- `o_pc` out XLEN: PC of decoded instruction.
- `o_Branch`, `o_MemRead`, `o_MemWrite`, `o_MemToReg`, `o_ALUSrcB`, `o_RegWrite`, `o_PCplus4`, `o_CSR_en` out 1 each.
- `o_ALUOp` out 3.
- `o_ALUSrcA` out 2: 0 = rs1, 1 = PC, 2 = zero.
- `o_Jump` out 2: 1 = JAL, 2 = JALR.
- `o_Ex` out 1: instruction raises an exception.
- `o_cause` out `CAUSE_W`: mcause code, valid when `o_Ex`.

## Operation
**Decode table** (combinational, then registered). All fields not listed are 0; there are no X values.
- OP (`0110011`): RegWrite, ALUOp=010.
- OP-IMM (`0010011`): ALUSrcB, RegWrite, ALUOp=011.
- LOAD (`0000011`): MemRead, MemToReg, ALUSrcB, RegWrite, ALUOp=000.
- STORE (`0100011`): MemWrite, ALUSrcB, ALUOp=000.
- BRANCH (`1100011`): Branch, ALUOp=001.
- LUI: ALUSrcA=2, ALUSrcB, RegWrite, ALUOp=100.
- AUIPC: ALUSrcA=1, ALUSrcB, RegWrite, ALUOp=100.
- JAL: RegWrite, Jump=1, PCplus4.
- JALR: ALUSrcB, RegWrite, ALUOp=100, Jump=2, PCplus4.
- FENCE: all zero (NOP), serialising.
- SYSTEM: RegWrite, CSR_en, serialising.

**Exceptions.** On any exception, all enables (RegWrite, MemRead, MemWrite, Branch, Jump, CSR_en, PCplus4) are forced 0 and `o_Ex`=1.
- ECALL: SYSTEM with f3=0, rs1=0, rd=0, f12=0 → cause 11.
- EBREAK: as ECALL but f12=1 → cause 3.
- Illegal instruction (cause 2):
  - unknown opcode, or bits[1:0]≠11;
  - LOAD with f3 ∈ {3,6,7};
  - STORE with f3>2;
  - BRANCH with f3 ∈ {2,3};
  - JALR with f3≠0;
  - OP with f7∉{0000000,0100000}, or f7=0100000 with f3∉{0,5};
  - OP-IMM shifts (f3=1 with f7≠0; f3=5 with f7∉{0000000,0100000}).

**State machine.**
- RUN:
  - `o_ready = !o_valid || i_ready`.
  - On accept of a non-serialising instruction, the decoded word loads into the output register.
  - On accept of a serialising instruction with `i_pipe_empty`=1 and the output slot free, it loads directly.
  - Otherwise the instruction is captured in the hold register → DRAIN.
- DRAIN:
  - `o_ready`=0.
  - When `i_pipe_empty`=1 and the output slot is free (`!o_valid || i_ready`), the held word loads into the output register → RUN.
- A serialising instruction that raises an exception is still serialised.

**Flush.** `i_flush`=1 clears `o_valid` and the hold register and forces RUN next cycle. Flush wins over a simultaneous accept; `o_ready` is 0 while `i_flush`=1.

## Timing
- Latency is 1 cycle from accept to `o_valid`.
- Full throughput of 1 instruction/cycle for non-serialising streams with `i_ready`=1.
- Output register holds stable while `o_valid && !i_ready`.
- DRAIN exit: the word appears the cycle after `i_pipe_empty` is sampled high with a free slot.
- Reset (async, any state): state=RUN, `o_valid`=0, hold register empty, all control outputs 0, `o_cause`=0, `o_pc`=0.
- `o_ready` is combinational from state, `o_valid`, `i_ready`, `i_flush`; it never depends on `i_valid`.

## Configuration
- `MAIN_CTRL_M_EXT_EN`:
  - Defined: OP with f7=0000001 (any f3) decodes as OP (RegWrite, ALUOp=010).
  - Undefined: that encoding is illegal, cause 2.

## Test plan
- Back-to-back ADD `0x002081B3`, LW `0x0000A183`, SW `0x0030A023` with `i_ready`=1 → three consecutive `o_valid` cycles with ALUOp 010/000/000; the LW word has MemRead=1, MemToReg=1.
- ECALL `0x00000073`, then EBREAK `0x00100073`, with `i_pipe_empty`=1 → `o_Ex`=1 with cause 11, then cause 3; RegWrite=0 and CSR_en=0 both times.
- CSRRW `0x34011073` with `i_pipe_empty`=0 for 5 cycles → `o_ready`=0 for 5 cycles; word issued 1 cycle after empty rises.
- `i_flush` asserted during DRAIN → `o_valid` stays 0, `o_ready`=1 the next cycle, held instruction never issued.
- Opcode `0x0000007F` and LOAD f3=3 `0x0000B183` → cause 2, all enables 0.
- MUL `0x022081B3` → cause 2 without the macro; legal OP with ALUOp=010 with it.
- `i_ready`=0 for 3 cycles with `o_valid`=1, then `i_rst_n` pulsed low mid-stall → outputs are stable while stalled, then all outputs are 0 immediately on reset.

Source files
------------

// File: rtl/main_ctrl_stage.sv
// Registered RV32I main-control decoder with valid/ready output register and
// SYSTEM/FENCE serialisation. Define MAIN_CTRL_M_EXT_EN to accept OP f7=0000001 (M extension).
module main_ctrl_stage #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [31:0]        i_Instr,
  input  logic [XLEN-1:0]    i_pc,
  input  logic               i_flush,
  input  logic               i_pipe_empty,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [XLEN-1:0]    o_pc,
  output logic               o_Branch,
  output logic               o_MemRead,
  output logic               o_MemWrite,
  output logic               o_MemToReg,
  output logic               o_ALUSrcB,
  output logic               o_RegWrite,
  output logic               o_PCplus4,
  output logic               o_CSR_en,
  output logic [2:0]         o_ALUOp,
  output logic [1:0]         o_ALUSrcA,
  output logic [1:0]         o_Jump,
  output logic               o_Ex,
  output logic [CAUSE_W-1:0] o_cause
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = CAUSE_W'(2);
  localparam logic [CAUSE_W-1:0] CAUSE_BREAK   = CAUSE_W'(3);
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL   = CAUSE_W'(11);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  typedef struct packed {
    logic               branch;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src_b;
    logic               reg_write;
    logic               pc_plus4;
    logic               csr_en;
    logic [2:0]         alu_op;
    logic [1:0]         alu_src_a;
    logic [1:0]         jump;
    logic               ex;
    logic [CAUSE_W-1:0] cause;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t      c;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       illegal;
    // NOTE: every field gets a default before the case so no path leaves a value unassigned.
    c       = '0;
    illegal = 1'b0;
    f7      = instr[31:25];
    f3      = instr[14:12];
    case (instr[6:0])
      OPC_OP: begin
        c.reg_write = 1'b1;
        c.alu_op    = 3'b010;
        illegal     = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)));
`ifdef MAIN_CTRL_M_EXT_EN
        if (f7 == 7'b0000001) illegal = 1'b0;
`endif
      end
      OPC_OP_IMM: begin
        c.alu_src_b = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = 3'b011;
        if (f3 == 3'd1)      illegal = (f7 != 7'b0000000);
        else if (f3 == 3'd5) illegal = !(f7 == 7'b0000000 || f7 == 7'b0100000);
      end
      OPC_LOAD: begin
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src_b  = 1'b1;
        c.reg_write  = 1'b1;
        illegal      = (f3 == 3'd3) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        c.mem_write = 1'b1;
        c.alu_src_b = 1'b1;
        illegal     = (f3 > 3'd2);
      end
      OPC_BRANCH: begin
        c.branch = 1'b1;
        c.alu_op = 3'b001;
        illegal  = (f3[2:1] == 2'b01);
      end
      OPC_LUI, OPC_AUIPC: begin
        c.alu_src_a = (instr[6:0] == OPC_LUI) ? 2'd2 : 2'd1;
        c.alu_src_b = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = 3'b100;
      end
      OPC_JAL: begin
        c.reg_write = 1'b1;
        c.jump      = 2'd1;
        c.pc_plus4  = 1'b1;
      end
      OPC_JALR: begin
        c.alu_src_b = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = 3'b100;
        c.jump      = 2'd2;
        c.pc_plus4  = 1'b1;
        illegal     = (f3 != 3'd0);
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        c.reg_write = 1'b1;
        c.csr_en    = 1'b1;
        if (f3 == 3'd0 && instr[19:15] == 5'd0 && instr[11:7] == 5'd0 && instr[31:21] == 11'd0) begin
          c.ex    = 1'b1;
          c.cause = instr[20] ? CAUSE_BREAK : CAUSE_ECALL;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      c.ex    = 1'b1;
      c.cause = CAUSE_ILLEGAL;
    end
    if (c.ex) begin
      c.reg_write = 1'b0;
      c.mem_read  = 1'b0;
      c.mem_write = 1'b0;
      c.branch    = 1'b0;
      c.jump      = 2'd0;
      c.csr_en    = 1'b0;
      c.pc_plus4  = 1'b0;
    end
    return c;
  endfunction

  logic [0:0]      state;
  logic [31:0]     hold_instr;
  logic [XLEN-1:0] hold_pc;
  ctrl_t           out_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;

  logic            slot_free, accept, in_serial, load_in, to_drain, load_hold;
  logic [31:0]     dec_instr;
  logic [XLEN-1:0] dec_pc;
  ctrl_t           dec;

  assign slot_free = !valid_q || i_ready;
  assign o_ready   = (state == ST_RUN) && slot_free && !i_flush;
  assign accept    = i_valid && o_ready;
  assign in_serial = (i_Instr[6:0] == OPC_FENCE) || (i_Instr[6:0] == OPC_SYSTEM);
  assign load_in   = accept && (!in_serial || i_pipe_empty);
  assign to_drain  = accept && in_serial && !i_pipe_empty;
  assign load_hold = (state == ST_DRAIN) && i_pipe_empty && slot_free && !i_flush;

  // In DRAIN the input side is stalled, so the decoder only ever sees the held word.
  assign dec_instr = (state == ST_DRAIN) ? hold_instr : i_Instr;
  assign dec_pc    = (state == ST_DRAIN) ? hold_pc : i_pc;
  assign dec       = decode(dec_instr);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_RUN;
      hold_instr <= '0;
      hold_pc    <= '0;
      out_q      <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else if (i_flush) begin
      state      <= ST_RUN;
      hold_instr <= '0;
      hold_pc    <= '0;
      valid_q    <= 1'b0;
    end else begin
      if (load_in || load_hold) begin
        out_q   <= dec;
        pc_q    <= dec_pc;
        valid_q <= 1'b1;
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end
      if (to_drain) begin
        hold_instr <= i_Instr;
        hold_pc    <= i_pc;
        state      <= ST_DRAIN;
      end else if (load_hold) begin
        state <= ST_RUN;
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_pc       = pc_q;
  assign o_Branch   = out_q.branch;
  assign o_MemRead  = out_q.mem_read;
  assign o_MemWrite = out_q.mem_write;
  assign o_MemToReg = out_q.mem_to_reg;
  assign o_ALUSrcB  = out_q.alu_src_b;
  assign o_RegWrite = out_q.reg_write;
  assign o_PCplus4  = out_q.pc_plus4;
  assign o_CSR_en   = out_q.csr_en;
  assign o_ALUOp    = out_q.alu_op;
  assign o_ALUSrcA  = out_q.alu_src_a;
  assign o_Jump     = out_q.jump;
  assign o_Ex       = out_q.ex;
  assign o_cause    = out_q.cause;

endmodule

// File: tb/tb_main_ctrl_stage.sv
// Self-checking bench for main_ctrl_stage: directed scenarios plus a randomized
// stream scored against an instruction-level reference model.
module tb_main_ctrl_stage;
  localparam int XLEN    = 32;
  localparam int CAUSE_W = 4;
`ifdef MAIN_CTRL_M_EXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic               i_clk, i_rst_n, i_valid, o_ready, i_flush, i_pipe_empty, o_valid, i_ready;
  logic [31:0]        i_Instr;
  logic [XLEN-1:0]    i_pc, o_pc;
  logic               o_Branch, o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrcB, o_RegWrite, o_PCplus4, o_CSR_en;
  logic [2:0]         o_ALUOp;
  logic [1:0]         o_ALUSrcA, o_Jump;
  logic               o_Ex;
  logic [CAUSE_W-1:0] o_cause;

  main_ctrl_stage #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_Instr(i_Instr), .i_pc(i_pc), .i_flush(i_flush), .i_pipe_empty(i_pipe_empty),
    .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
    .o_Branch(o_Branch), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_MemToReg(o_MemToReg),
    .o_ALUSrcB(o_ALUSrcB), .o_RegWrite(o_RegWrite), .o_PCplus4(o_PCplus4), .o_CSR_en(o_CSR_en),
    .o_ALUOp(o_ALUOp), .o_ALUSrcA(o_ALUSrcA), .o_Jump(o_Jump), .o_Ex(o_Ex), .o_cause(o_cause)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       br, mr, mw, m2r, srcb, rw, pc4, csr;
    logic [2:0] aluop;
    logic [1:0] srca, jump;
    logic       ex;
    logic [3:0] cause;
  } word_t;

  int checks = 0;
  int errors = 0;

  // Reference decode written straight from the instruction-set rules.
  function automatic word_t model(input logic [31:0] ins);
    word_t w;
    int    op, f3, f7, cause;
    bit    legal;
    w = '0; legal = 1'b1; cause = 0;
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    if (op == 'h33) begin
      w.rw = 1; w.aluop = 3'd2;
      legal = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5)) || (MEXT && f7 == 1);
    end else if (op == 'h13) begin
      w.srcb = 1; w.rw = 1; w.aluop = 3'd3;
      if (f3 == 1) legal = (f7 == 0);
      if (f3 == 5) legal = (f7 == 0 || f7 == 'h20);
    end else if (op == 'h03) begin
      w.mr = 1; w.m2r = 1; w.srcb = 1; w.rw = 1;
      legal = !(f3 == 3 || f3 == 6 || f3 == 7);
    end else if (op == 'h23) begin
      w.mw = 1; w.srcb = 1; legal = (f3 <= 2);
    end else if (op == 'h63) begin
      w.br = 1; w.aluop = 3'd1; legal = !(f3 == 2 || f3 == 3);
    end else if (op == 'h37) begin
      w.srca = 2; w.srcb = 1; w.rw = 1; w.aluop = 3'd4;
    end else if (op == 'h17) begin
      w.srca = 1; w.srcb = 1; w.rw = 1; w.aluop = 3'd4;
    end else if (op == 'h6F) begin
      w.rw = 1; w.jump = 1; w.pc4 = 1;
    end else if (op == 'h67) begin
      w.srcb = 1; w.rw = 1; w.aluop = 3'd4; w.jump = 2; w.pc4 = 1; legal = (f3 == 0);
    end else if (op == 'h0F) begin
      legal = 1'b1;
    end else if (op == 'h73) begin
      w.rw = 1; w.csr = 1;
      if (ins[19:7] == 0 && ins[31:21] == 0) cause = ins[20] ? 3 : 11;
    end else begin
      legal = 1'b0;
    end
    if (!legal) cause = 2;
    if (cause != 0) begin
      w.rw = 0; w.mr = 0; w.mw = 0; w.br = 0; w.jump = 0; w.csr = 0; w.pc4 = 0;
      w.ex = 1; w.cause = cause[3:0];
    end
    return w;
  endfunction

  function automatic word_t act();
    word_t a;
    a = {o_Branch, o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrcB, o_RegWrite, o_PCplus4, o_CSR_en,
         o_ALUOp, o_ALUSrcA, o_Jump, o_Ex, o_cause};
    return a;
  endfunction

  function automatic bit is_serial(input logic [31:0] ins);
    return ins[6:0] == 7'h0F || ins[6:0] == 7'h73;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 13);
    case (k)
      0:  r[6:0] = 7'h33;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h03;  3: r[6:0] = 7'h23;
      4:  r[6:0] = 7'h63;  5: r[6:0] = 7'h37;  6: r[6:0] = 7'h17;  7: r[6:0] = 7'h6F;
      8:  r[6:0] = 7'h67;  9: r[6:0] = 7'h0F;  10: r[6:0] = 7'h73;
      11: r = 32'h0000_0073 | (32'($urandom_range(0, 1)) << 20);
      12: ;
      default: begin r[6:0] = 7'h67; r[14:12] = 3'd0; end
    endcase
    if (k <= 1) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 0; i_flush = 0; i_ready = 1; i_pipe_empty = 1; i_Instr = '0; i_pc = '0;
  endtask

  task automatic test_reset();
    idle();
    i_rst_n = 0;
    step(); step();
    if ({o_valid, o_pc, act()} !== '0) begin
      errors++; $display("FAIL reset_outputs: got valid=%b pc=%h word=%h, expected all zero", o_valid, o_pc, act());
    end
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", o_ready); end
    checks++;
    i_rst_n = 1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [3];
    logic [2:0]  ops  [3];
    prog = '{32'h002081B3, 32'h0000A183, 32'h0030A023};
    ops  = '{3'b010, 3'b000, 3'b000};
    idle();
    for (int i = 0; i < 3; i++) begin
      i_valid = 1; i_Instr = prog[i]; i_pc = 32'h100 + 32'(4 * i);
      #1;
      if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b, expected 1", i, o_ready); end
      checks++;
      step();
      if (o_valid !== 1'b1 || act() !== model(prog[i]) || o_pc !== 32'h100 + 32'(4 * i) || o_ALUOp !== ops[i]) begin
        errors++; $display("FAIL b2b_word[%0d]: got v=%b word=%h pc=%h, expected v=1 word=%h pc=%h",
                           i, o_valid, act(), o_pc, model(prog[i]), 32'h100 + 32'(4 * i));
      end
      checks++;
      if (i == 1 && (o_MemRead !== 1'b1 || o_MemToReg !== 1'b1)) begin
        errors++; $display("FAIL b2b_lw_mem: got MemRead=%b MemToReg=%b, expected 1 1", o_MemRead, o_MemToReg);
      end
      if (i == 1) checks++;
    end
    i_valid = 0;
    step();
    if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got o_valid=%b, expected 0", o_valid); end
    checks++;
  endtask

  task automatic test_system();
    logic [31:0] ins [2];
    logic [3:0]  cs  [2];
    ins = '{32'h00000073, 32'h00100073};
    cs  = '{4'd11, 4'd3};
    idle();
    for (int i = 0; i < 2; i++) begin
      i_valid = 1; i_Instr = ins[i]; i_pc = 32'h180 + 32'(4 * i);
      step();
      if (o_valid !== 1'b1 || o_Ex !== 1'b1 || o_cause !== cs[i] || o_RegWrite !== 1'b0 ||
          o_CSR_en !== 1'b0 || act() !== model(ins[i])) begin
        errors++; $display("FAIL sys_exc[%0d]: got v=%b ex=%b cause=%0d rw=%b csr=%b, expected v=1 ex=1 cause=%0d rw=0 csr=0",
                           i, o_valid, o_Ex, o_cause, o_RegWrite, o_CSR_en, cs[i]);
      end
      checks++;
    end
    idle();
    step();
  endtask

  task automatic test_serialise();
    idle();
    i_pipe_empty = 0;
    i_valid = 1; i_Instr = 32'h34011073; i_pc = 32'h200;
    step();
    i_valid = 0;
    for (int k = 0; k < 5; k++) begin
      if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
        errors++; $display("FAIL drain_hold[%0d]: got ready=%b valid=%b, expected 0 0", k, o_ready, o_valid);
      end
      checks++;
      if (k < 4) step();
    end
    i_pipe_empty = 1;
    step();
    if (o_valid !== 1'b1 || act() !== model(32'h34011073) || o_pc !== 32'h200 || o_ready !== 1'b1) begin
      errors++; $display("FAIL drain_issue: got v=%b word=%h pc=%h ready=%b, expected v=1 word=%h pc=200 ready=1",
                         o_valid, act(), o_pc, o_ready, model(32'h34011073));
    end
    checks++;
    step();
  endtask

  task automatic test_flush();
    idle();
    i_pipe_empty = 0;
    i_valid = 1; i_Instr = 32'h0000000F; i_pc = 32'h300;
    step();
    i_valid = 0;
    step();
    i_flush = 1;
    #1;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_drain_ready: got %b, expected 0", o_ready); end
    checks++;
    step();
    i_flush = 0; i_pipe_empty = 1;
    #1;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL flush_exit: got valid=%b ready=%b, expected 0 1", o_valid, o_ready);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      step();
      if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_no_issue[%0d]: got valid=%b, expected 0", k, o_valid); end
      checks++;
    end
    // Flush against a simultaneous offer and a stalled valid output.
    i_ready = 0; i_valid = 1; i_Instr = 32'h002081B3; i_pc = 32'h310;
    step();
    i_flush = 1; i_Instr = 32'h0000A183;
    #1;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_run_ready: got %b, expected 0", o_ready); end
    checks++;
    i_ready = 1;
    step();
    i_flush = 0; i_valid = 0;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got valid=%b, expected 0", o_valid); end
    checks++;
    step();
    if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_wins: got valid=%b, expected 0", o_valid); end
    checks++;
  endtask

  task automatic test_illegal();
    logic [31:0] bad [8];
    logic [31:0] ok  [2];
    bad = '{32'h0000007F, 32'h0000B183, 32'h00003023, 32'h00002063,
            32'h00001067, 32'h40001033, 32'h40001013, 32'h00000032};
    ok  = '{32'h40005033, 32'h40005013};
    idle();
    for (int i = 0; i < 8; i++) begin
      i_valid = 1; i_Instr = bad[i]; i_pc = 32'h400 + 32'(4 * i);
      step();
      if (o_Ex !== 1'b1 || o_cause !== 4'd2 ||
          {o_RegWrite, o_MemRead, o_MemWrite, o_Branch, o_Jump, o_CSR_en, o_PCplus4} !== 8'd0 ||
          act() !== model(bad[i])) begin
        errors++; $display("FAIL illegal[%0d] %h: got word=%h, expected ex=1 cause=2 enables=0 (%h)",
                           i, bad[i], act(), model(bad[i]));
      end
      checks++;
    end
    for (int i = 0; i < 2; i++) begin
      i_valid = 1; i_Instr = ok[i];
      step();
      if (o_Ex !== 1'b0 || act() !== model(ok[i])) begin
        errors++; $display("FAIL legal_shift[%0d]: got word=%h, expected %h", i, act(), model(ok[i]));
      end
      checks++;
    end
    idle();
    step();
  endtask

  task automatic test_mext();
    idle();
    i_valid = 1; i_Instr = 32'h022081B3; i_pc = 32'h500;
    step();
    i_valid = 0;
    if (MEXT) begin
      if (o_Ex !== 1'b0 || o_ALUOp !== 3'b010 || o_RegWrite !== 1'b1) begin
        errors++; $display("FAIL mul_legal: got ex=%b aluop=%b rw=%b, expected 0 010 1", o_Ex, o_ALUOp, o_RegWrite);
      end
    end else begin
      if (o_Ex !== 1'b1 || o_cause !== 4'd2 || o_RegWrite !== 1'b0) begin
        errors++; $display("FAIL mul_illegal: got ex=%b cause=%0d rw=%b, expected 1 2 0", o_Ex, o_cause, o_RegWrite);
      end
    end
    checks++;
    step();
  endtask

  task automatic test_stall_reset();
    word_t exp;
    idle();
    i_ready = 0; i_valid = 1; i_Instr = 32'h002081B3; i_pc = 32'h600;
    exp = model(32'h002081B3);
    step();
    i_Instr = 32'h0000A183; i_pc = 32'h604;
    for (int k = 0; k < 3; k++) begin
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || act() !== exp || o_pc !== 32'h600) begin
        errors++; $display("FAIL stall_hold[%0d]: got ready=%b v=%b word=%h pc=%h, expected 0 1 %h 600",
                           k, o_ready, o_valid, act(), o_pc, exp);
      end
      checks++;
      step();
    end
    #2 i_rst_n = 0;
    #1;
    if ({o_valid, o_pc, act()} !== '0) begin
      errors++; $display("FAIL async_reset: got v=%b pc=%h word=%h, expected all zero", o_valid, o_pc, act());
    end
    checks++;
    idle();
    step();
    i_rst_n = 1;
    step();
  endtask

  task automatic test_random();
    word_t       exp_q [$];
    logic [31:0] pc_q  [$];
    logic [31:0] ins_q [$];
    word_t       e;
    logic [31:0] p, ins;
    bool_loop: for (int cyc = 0; cyc < 3020; cyc++) begin
      if (cyc < 3000) begin
        i_valid      = ($urandom_range(0, 3) != 0);
        i_Instr      = rand_instr();
        i_pc         = $urandom;
        i_ready      = ($urandom_range(0, 3) != 0);
        i_pipe_empty = ($urandom_range(0, 3) != 0);
      end else begin
        idle();
      end
      #1;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious: cycle %0d got word=%h pc=%h, expected no output", cyc, act(), o_pc);
        end else begin
          e = exp_q.pop_front(); p = pc_q.pop_front(); ins = ins_q.pop_front();
          if (act() !== e || o_pc !== p) begin
            errors++; $display("FAIL rand_word: cycle %0d instr %h got word=%h pc=%h, expected word=%h pc=%h",
                               cyc, ins, act(), o_pc, e, p);
          end
        end
        checks++;
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_Instr)); pc_q.push_back(i_pc); ins_q.push_back(i_Instr);
        if (is_serial(i_Instr) && exp_q.size() > 1) begin
          errors++; $display("FAIL rand_serial_accept: cycle %0d got %0d words ahead, expected 0", cyc, exp_q.size() - 1);
        end
      end
      @(posedge i_clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_leftover: got %0d words undelivered, expected 0", exp_q.size());
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_system();
    test_serialise();
    test_flush();
    test_illegal();
    test_mext();
    test_stall_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
